// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch port and the data port.
// Data wins by default; fetch gets a turn after MAX_DATA_STREAK back-to-back data grants.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned TIMEOUT         = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_err
);

    localparam int unsigned STREAK_W = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
    localparam int unsigned TCNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [TCNT_W-1:0]   TCNT_LAST  = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DATA_BUSY  = 2'd1,
        FETCH_BUSY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                we_q;
    logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;
    logic                grant_d, grant_f;
    logic                fetch_due;
    logic                expire;

    // Fetch is owed a turn once the data streak hits its cap while fetch waits
    assign fetch_due = if_req && (MAX_DATA_STREAK != 0) && (streak_q == STREAK_MAX);
    assign expire    = !mem_ack && (tcnt_q == TCNT_LAST);

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        tcnt_d   = tcnt_q;
        grant_d  = 1'b0;
        grant_f  = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        if_ready = 1'b0;
        d_ready  = 1'b0;
        bus_err  = 1'b0;
        if_rdata = if_rdata_q;
        d_rdata  = d_rdata_q;

        case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (d_req && !fetch_due) begin
                    state_d = DATA_BUSY;
                    grant_d = 1'b1;
                    if (!if_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else if (if_req) begin
                    state_d  = FETCH_BUSY;
                    grant_f  = 1'b1;
                    streak_d = '0;
                end else begin
                    streak_d = '0;
                end
            end

            DATA_BUSY: begin
                mem_req = 1'b1;
                mem_we  = we_q;
                if (mem_ack || expire) begin
                    d_ready = 1'b1;
                    bus_err = !mem_ack;
                    state_d = IDLE;
                    tcnt_d  = '0;
                    if (mem_ack && !we_q) begin
                        d_rdata = mem_rdata;
                    end
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end

            FETCH_BUSY: begin
                mem_req = 1'b1;
                if (mem_ack || expire) begin
                    if_ready = 1'b1;
                    bus_err  = !mem_ack;
                    state_d  = IDLE;
                    tcnt_d   = '0;
                    if (mem_ack) begin
                        if_rdata = mem_rdata;
                    end
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            streak_q <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            tcnt_q   <= tcnt_d;
        end
    end

    // Request payload is captured from the winning port on the grant edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_d) begin
            we_q      <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
        end else if (grant_f) begin
            we_q     <= 1'b0;
            mem_addr <= if_addr;
        end
    end

    // Read-data holds follow the visible rdata, which only differs on a read completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_rdata_q <= if_rdata;
            d_rdata_q  <= d_rdata;
        end
    end

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = d_req & ~d_ready;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage, loads/stores).
- Sequences each access with a req/ack handshake to a variable-latency memory.
- Grants the data port first by default, with a bounded-starvation rule for fetch.
- Exports stall indications that the pipeline control uses to freeze PC/IF/ID or the MEM stage.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch waits; 0 = strict data priority
TIMEOUT, 64, cycles to wait for mem_ack before aborting (≥2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held with if_addr until if_ready
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction
if_ready  out  1  fetch completion pulse
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ready
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data
d_ready  out  1  data completion pulse
mem_req  out  1  memory request, held until ack or abort
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address (registered)
mem_wdata  out  DATA_W  memory write data (registered)
mem_rdata  in  DATA_W  memory read data, valid when mem_ack
mem_ack  in  1  single-cycle completion from memory
stall_if  out  1  if_req & ~if_ready
stall_mem  out  1  d_req & ~d_ready
bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on port reset; asserting it forces every register immediately.
- Reset values: state IDLE; mem_req, mem_we, if_ready, d_ready, bus_err = 0; mem_addr, mem_wdata, if_rdata/d_rdata hold registers = 0; streak and timeout counters = 0.
- States:
  - IDLE: mem_req = 0.
  - DATA_BUSY: mem_req = 1; mem_we = registered d_we.
  - FETCH_BUSY: mem_req = 1; mem_we = 0.
- Arbitration in IDLE, evaluated every cycle:
  - If d_req and not (if_req and MAX_DATA_STREAK ≠ 0 and streak == MAX_DATA_STREAK): go to DATA_BUSY.
  - Else if if_req: go to FETCH_BUSY.
  - Else: stay in IDLE.
  - On the grant edge, mem_addr and mem_wdata (data only) are latched from the granted port.
- Streak counter:
  - Increments on a data grant while if_req = 1, saturating at MAX_DATA_STREAK.
  - Clears on a fetch grant, or in any IDLE cycle with if_req = 0.
- Latency: the grant registers one cycle after the request is seen; mem_req rises on the next cycle.
- Completion: in a BUSY state with mem_ack = 1, the owning port's ready is 1 combinationally in that same cycle.
  - The port's rdata shows mem_rdata in that cycle, and the hold register captures it (loads and fetches only; stores do not update d_rdata).
  - State returns to IDLE on that edge.
  - Minimum service time: req seen → ready = 3 cycles with zero-wait memory.
  - One IDLE turnaround cycle separates back-to-back grants.
- rdata outputs: between completions each rdata shows its hold register.
- mem_ack while IDLE: ignored; no ready is pulsed.
- Timeout:
  - The counter counts BUSY cycles without ack.
  - On reaching TIMEOUT: mem_req drops, the owner's ready pulses with rdata unchanged, bus_err pulses in the same cycle, and state goes to IDLE.
  - An ack arriving in the same cycle as expiry wins; no bus_err is raised.
- Requester dropping req mid-transaction (protocol violation): the transaction still completes; ready still pulses.
- Simultaneous if_req and d_req arriving in the same cycle: resolved by the arbitration rule above. The losing port keeps its stall asserted.
- Reset mid-transaction: mem_req drops immediately and the in-flight access is lost; requesters re-issue after reset releases.

Test Plan:
1. Zero-wait fetch: if_req = 1, if_addr = 0x0000_0010, mem_ack the cycle after mem_req rises, mem_rdata = 0x0000_0013 -> if_ready pulses one cycle with if_rdata = 0x0000_0013; mem_we = 0; stall_if = 1 until that cycle.
2. Store: d_req = 1, d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF, ack after 3 wait cycles -> mem_we = 1, mem_addr = 0x100, mem_wdata = 0xDEADBEEF held for 4 cycles; d_ready pulses; d_rdata unchanged (0).
3. Contention: if_req and d_req held continuously, MAX_DATA_STREAK = 4, zero-wait memory -> grant order D,D,D,D,F,D,D,D,D,F; with MAX_DATA_STREAK = 0 -> fetch is never granted.
4. Timeout: d_req load, mem_ack never asserted, TIMEOUT = 8 -> mem_req high for exactly 8 cycles, then d_ready and bus_err pulse together; next cycle is IDLE. Variant with ack in the 8th cycle -> no bus_err, d_rdata = mem_rdata.
5. Reset mid-operation: assert reset (low) 2 cycles into FETCH_BUSY, asynchronously to clk -> mem_req = 0 immediately, if_ready never pulses; after release with if_req still high, a fresh fetch is granted.
6. Stray ack: mem_ack = 1 while IDLE -> no ready pulse, no rdata change, state stays IDLE.
